data_mem_load_unit: RTL and testbench

- Load-side counterpart of the store data aligner.
- Accepts a load request from the core (op + byte address), issues a word-aligned read to data memory over a valid/ready request channel, and waits for the response.
- Extracts the addressed byte/half/word, sign- or zero-extends it, and returns it to the core over a valid/ready response channel.
- Detects misaligned and non-load opcodes and returns a fault without touching memory.

---
 rtl/data_mem_pkg.sv | 20 ++
 rtl/data_mem_lw_extract.sv | 25 ++
 rtl/data_mem_load_unit.sv | 98 +++++++++
 tb/tb_data_mem_load_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared load/store opcodes, load FSM states and request legality check
package data_mem_pkg;
  localparam logic [2:0] LB_OP_LOAD  = 3'd0;
  localparam logic [2:0] LH_OP_LOAD  = 3'd1;
  localparam logic [2:0] LW_OP_LOAD  = 3'd2;
  localparam logic [2:0] LBU_OP_LOAD = 3'd3;
  localparam logic [2:0] LHU_OP_LOAD = 3'd4;
  localparam logic [2:0] SB_OP_STORE = 3'd5;
  localparam logic [2:0] SH_OP_STORE = 3'd6;
  localparam logic [2:0] SW_OP_STORE = 3'd7;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} load_state_e;

  // store opcodes, odd halfword addresses and unaligned words never reach memory
  function automatic logic load_illegal(input logic [2:0] op, input logic [1:0] lo);
    return (op inside {SB_OP_STORE, SH_OP_STORE, SW_OP_STORE}) ||
           ((op inside {LH_OP_LOAD, LHU_OP_LOAD}) && lo[0]) ||
           (op == LW_OP_LOAD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/data_mem_lw_extract.sv
// data_mem_lw_extract: selects the addressed byte/half/word lane and sign- or zero-extends it
module data_mem_lw_extract
  import data_mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? word[31:16] : word[15:0];
  // extension by opcode; LW and anything else pass the whole word
  always_comb begin
    data = word;
    case (op)
      LB_OP_LOAD:  data = {{24{b[7]}}, b};
      LH_OP_LOAD:  data = {{16{h[15]}}, h};
      LBU_OP_LOAD: data = {24'd0, b};
      LHU_OP_LOAD: data = {16'd0, h};
      default:     data = word;
    endcase
  end
endmodule

// File: rtl/data_mem_load_unit.sv
// data_mem_load_unit: sequences core loads to word-aligned memory reads; LOAD_TIMEOUT_EN adds a WAIT abort
module data_mem_load_unit
  import data_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req_valid,
  output logic              load_req_ready,
  input  logic [2:0]        lw_sw_op,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              load_rsp_valid,
  input  logic              load_rsp_ready,
  output logic [31:0]       load_data,
  output logic              load_fault
);
  load_state_e       state, state_n;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q, ext;
  logic              fault_q, req_fault, timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign req_fault      = load_illegal(lw_sw_op, load_addr[1:0]);
  assign load_req_ready = state == IDLE;
  assign mem_req_valid  = state == REQ;
  assign load_rsp_valid = state == RESP;
  assign mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
  assign load_data      = data_q;
  assign load_fault     = fault_q;

  data_mem_lw_extract u_extract (
    .op     (op_q),
    .addr_lo(addr_q[1:0]),
    .word   (mem_rsp_data),
    .data   (ext)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // WAIT cycle counter, held at zero while the request is outstanding in REQ
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (state == REQ) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
  assign timeout = state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // next state; a memory response beats a same-cycle timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load_req_valid) state_n = req_fault ? RESP : REQ;
      REQ:     if (mem_req_ready) state_n = WAIT;
      WAIT:    if (mem_rsp_valid || timeout) state_n = RESP;
      RESP:    if (load_rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // request capture and result/fault registers, stable through RESP
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (state == IDLE && load_req_valid) begin
      op_q    <= lw_sw_op;
      addr_q  <= load_addr;
      data_q  <= '0;
      fault_q <= req_fault;
    end else if (state == WAIT && mem_rsp_valid) begin
      data_q  <= ext;
      fault_q <= 1'b0;
    end else if (timeout) begin
      data_q  <= '0;
      fault_q <= 1'b1;
    end
endmodule

// File: tb/tb_data_mem_load_unit.sv
// tb_data_mem_load_unit: scoreboard bench for data_mem_load_unit
module tb_data_mem_load_unit;
  logic        clk = 0, rst_n = 0;
  logic        load_req_valid = 0, load_req_ready;
  logic [2:0]  lw_sw_op = 0;
  logic [31:0] load_addr = 0, mem_addr, mem_rsp_data = 0, load_data;
  logic        mem_req_valid, mem_req_ready = 1, mem_rsp_valid = 0;
  logic        load_rsp_valid, load_rsp_ready = 1, load_fault;
  int          ncmp = 0, nerr = 0, mem_req_cnt = 0, rsp_cnt = 0;
  logic [32:0] exp_q[$];

  data_mem_load_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_req_valid(load_req_valid), .load_req_ready(load_req_ready),
    .lw_sw_op(lw_sw_op), .load_addr(load_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .load_rsp_valid(load_rsp_valid), .load_rsp_ready(load_rsp_ready),
    .load_data(load_data), .load_fault(load_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*addr[1:0] +: 8];
    h = word[16*addr[1] +: 16];
    case (op)
      3'd0: return {1'b0, {24{b[7]}}, b};
      3'd1: return addr[0] ? {1'b1, 32'd0} : {1'b0, {16{h[15]}}, h};
      3'd2: return addr[1:0] != 0 ? {1'b1, 32'd0} : {1'b0, word};
      3'd3: return {1'b0, 24'd0, b};
      3'd4: return addr[0] ? {1'b1, 32'd0} : {1'b0, 16'd0, h};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // handshakes are observed mid-cycle, settled before the edge that completes them
  always @(negedge clk) if (rst_n) begin
    if (mem_req_valid && mem_req_ready) mem_req_cnt++;
    if (load_rsp_valid && load_rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
      else check("rsp", {load_fault, load_data}, exp_q.pop_front());
    end
  end

  task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] word,
                     input int req_stall, input int rsp_stall);
    logic [32:0] e;
    e = model(op, addr, word);
    exp_q.push_back(e);
    mem_req_ready  = req_stall == 0;
    load_rsp_ready = rsp_stall == 0;
    lw_sw_op = op;
    load_addr = addr;
    load_req_valid = 1;
    tick();
    load_req_valid = 0;
    load_addr = $urandom;
    if (!e[32]) begin
      check("mem_req_valid", mem_req_valid, 1);
      check("mem_addr", mem_addr, {addr[31:2], 2'b00});
      for (int i = 0; i < req_stall; i++) begin
        tick();
        check("mem_addr_hold", {mem_req_valid, mem_addr}, {1'b1, addr[31:2], 2'b00});
      end
      mem_req_ready = 1;
      tick();
      mem_rsp_valid = 1;
      mem_rsp_data = word;
      tick();
      mem_rsp_valid = 0;
      mem_rsp_data = $urandom;
    end else check("fault_no_mem", mem_req_valid, 0);
    check("rsp_valid", load_rsp_valid, 1);
    for (int i = 0; i < rsp_stall; i++) begin
      check("rsp_hold", {load_rsp_valid, load_fault, load_data}, {1'b1, e});
      tick();
    end
    load_rsp_ready = 1;
    tick();
    check("back_idle", {load_rsp_valid, load_req_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int m0, r0;
    logic [32:0] e;
    repeat (2) tick();
    check("reset_outs", {load_req_ready, mem_req_valid, load_rsp_valid, load_fault, load_data, mem_addr},
          {4'b1000, 64'd0});
    rst_n = 1;
    tick();
    run(3'd0, 32'h103, 32'h80AABBCC, 0, 0);
    run(3'd4, 32'h202, 32'h9234ABCD, 0, 0);
    run(3'd1, 32'h202, 32'h9234ABCD, 0, 0);
    run(3'd2, 32'h301, 32'h12345678, 0, 0);
    run(3'd6, 32'h100, 32'h12345678, 0, 0);
    run(3'd3, 32'h101, 32'h00F1E200, 0, 0);
    run(3'd2, 32'h300, 32'hCAFEF00D, 0, 0);
    run(3'd1, 32'h201, 32'hCAFEF00D, 0, 0);
    run(3'd0, 32'h100, 32'h0000007F, 0, 0);
    run(3'd1, 32'h200, 32'h00008001, 0, 0);
    m0 = mem_req_cnt;
    r0 = rsp_cnt;
    run(3'd2, 32'h500, 32'hDEADBEEF, 4, 3);
    check("one_mem_req", mem_req_cnt - m0, 1);
    check("one_rsp", rsp_cnt - r0, 1);
    lw_sw_op = 3'd2;
    load_addr = 32'h404;
    load_req_valid = 1;
    tick();
    load_req_valid = 0;
    tick();
    rst_n = 0;
    #1;
    check("reset_mid_wait", {load_req_ready, mem_req_valid, load_rsp_valid, load_fault, load_data, mem_addr},
          {4'b1000, 64'd0});
    tick();
    rst_n = 1;
    mem_rsp_valid = 1;
    mem_rsp_data = 32'h55AA55AA;
    tick();
    mem_rsp_valid = 0;
    tick();
    check("stale_rsp_ignored", {load_rsp_valid, load_req_ready, mem_req_valid}, 3'b010);
    for (int i = 0; i < 12; i++)
      run(3'($urandom_range(0, 7)), 32'h800 + $urandom_range(0, 15), $urandom,
          $urandom_range(0, 2), $urandom_range(0, 2));
`ifdef LOAD_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'd0});
    lw_sw_op = 3'd2;
    load_addr = 32'h600;
    load_req_valid = 1;
    tick();
    load_req_valid = 0;
    tick();
    repeat (7) tick();
    check("timeout_wait8", load_rsp_valid, 0);
    tick();
    check("timeout_fault", {load_rsp_valid, load_fault}, 2'b11);
    tick();
    e = model(3'd2, 32'h604, 32'h13579BDF);
    exp_q.push_back(e);
    load_addr = 32'h604;
    load_req_valid = 1;
    tick();
    load_req_valid = 0;
    tick();
    repeat (7) tick();
    mem_rsp_valid = 1;
    mem_rsp_data = 32'h13579BDF;
    tick();
    mem_rsp_valid = 0;
    check("timeout_rsp_wins", {load_rsp_valid, load_fault, load_data}, {1'b1, e});
    tick();
`endif
    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
